odesa_layer_param: RTL
======================

# odesa_layer_param

Parametrised supervised ODESA classification layer, the next generation of the fixed 6-input/3-neuron second layer. It maintains a per-input linear-decay time surface and scores all neurons serially against a snapshot of that surface. It emits a winner-take-all output spike and, when a label accompanies the event, applies local (LAS) and global (GAS) attention updates to the stored weights and thresholds. It sits between a feature layer's spike outputs and the label/readout logic.

## Interface
- P_N_IN, 6, input channels
- P_N_NEU, 3, neurons; must be a multiple of P_N_LBL
- P_N_LBL, 3, label classes; neuron j belongs to class j/(P_N_NEU/P_N_LBL)
- P_WIDTH, 9, weight width; time-surface entries are P_WIDTH+1 bits, max 2^P_WIDTH
- P_ETA, 8, learning-rate shift
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_event  in  P_N_IN  input spikes, one bit per channel
- i_label  in  P_N_LBL  one-hot label, sampled with the triggering event; 0 = no training
- i_tick  in  1  time-surface decay strobe
- i_train_en  in  1  enables LAS/GAS updates
- o_tr  out  P_N_IN*(P_WIDTH+1)  live time surface, channel 0 in LSBs
- o_spike  out  P_N_NEU  one-hot winner pulse
- o_ready  out  1  high in IDLE
- o_drop  out  1  pulse: event arrived while busy
- o_las  out  1  pulse: correct-class update applied
- o_gas  out  1  pulse: global attention applied

## Operation
- Time surface: tr[i] is set to 2^P_WIDTH on i_event[i]. Otherwise, on i_tick, tr[i] decrements by 1, saturating at 0. Event beats tick on the same cycle. The surface updates in every state.
- FSM IDLE -> ACCUM -> CMP -> OUT -> IDLE.
- IDLE: any i_event bit → snapshot the surface (including this cycle's event bits) and latch i_label (lowest set bit if several); → ACCUM with k=0.
- ACCUM: P_N_IN cycles. Each cycle, acc[j] += w[j][k]*snap[k] for all j, unsigned. acc width = 2*P_WIDTH+1+clog2(P_N_IN).
- CMP: winner = neuron with largest acc[j] satisfying acc[j] >= thr[j]; lowest index wins ties. "No winner" is valid.
- OUT (one cycle): o_spike = one-hot winner, or 0 if none. If i_train_en was high at the trigger and the label is nonzero:
  - winner in labelled class → LAS: w[win][i] += (snap[i]-w[win][i])>>>P_ETA (signed arithmetic shift) for all i; thr[win] += (acc[win]-thr[win])>>>P_ETA; o_las=1.
  - otherwise (no winner or wrong class) → GAS: thr[j] -= max(thr[j]>>P_ETA,1), saturating at 0, for every j in the labelled class; o_gas=1.
- Events arriving in ACCUM/CMP/OUT update the surface and pulse o_drop. They start no inference.
- Reset: tr=0, weights=2^(P_WIDTH-1), thr=0, FSM=IDLE, o_spike=0, o_ready=1, o_drop/o_las/o_gas=0. Reset mid-inference aborts with no spike and no update.

## Timing
- Event sampled at edge 0. ACCUM occupies cycles 1..P_N_IN, CMP cycle P_N_IN+1, OUT cycle P_N_IN+2.
- o_spike/o_las/o_gas are high for exactly cycle P_N_IN+2. Weights/thresholds are updated at the end of that cycle. o_ready is high again at P_N_IN+3.
- An event in cycle P_N_IN+3 (IDLE) is accepted; back-to-back throughput is one inference per P_N_IN+3 cycles.
- o_tr is registered and shows a set/decay one cycle after the event/tick.

## Configuration
- ODESA_GAS_EN: when defined, GAS behaves as above. When undefined, misses and wrong-class wins change no state, o_gas is tied 0, and LAS is unchanged.

## Test plan
- Reset, defaults → o_tr=0, o_spike=0, o_ready=1, all weights 256, all thresholds 0.
- i_event=6'b000001, i_train_en=0 → acc all 131072, tie → o_spike=3'b001 at cycle 8, o_ready back at cycle 9, no weight change.
- Same event with i_label=3'b001, i_train_en=1 → o_las at cycle 8; w0[0]=257, w0[1..5]=255, thr0=512; other neurons unchanged.
- After the previous case, event ch0 with label 3'b010 → winner neuron0 (wrong class). With ODESA_GAS_EN: o_gas=1, thr1 stays 0 (saturation), thr0 stays 512. Without it: no o_gas, no change.
- Event ch2 then 5 i_tick pulses → tr[2]=507. Tick and event on ch2 in the same cycle → tr[2]=512.
- Event ch1 during ACCUM of a prior inference → o_drop pulse, tr[1]=512, exactly one o_spike pulse; assert i_rst at cycle 4 of an inference → no spike, all state at reset values.

Source files
------------

// File: rtl/odesa_layer_param.sv
// Supervised ODESA classification layer: per-channel decaying time surface, serial
// neuron scoring, winner-take-all spike, LAS/GAS learning. Optional GAS: `ODESA_GAS_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for an event; surface snapshot and label latched on accept
// S_ACCUM | one input channel per cycle accumulated into every neuron
// S_CMP   | winner-take-all selection against per-neuron thresholds
// S_OUT   | spike/las/gas pulse; weights and thresholds updated at end of cycle
module odesa_layer_param #(
    parameter int P_N_IN  = 6,
    parameter int P_N_NEU = 3,
    parameter int P_N_LBL = 3,
    parameter int P_WIDTH = 9,
    parameter int P_ETA   = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [P_N_IN-1:0]               i_event,
    input  logic [P_N_LBL-1:0]              i_label,
    input  logic                            i_tick,
    input  logic                            i_train_en,
    output logic [P_N_IN*(P_WIDTH+1)-1:0]   o_tr,
    output logic [P_N_NEU-1:0]              o_spike,
    output logic                            o_ready,
    output logic                            o_drop,
    output logic                            o_las,
    output logic                            o_gas
);
    localparam int TW  = P_WIDTH + 1;
    localparam int AW  = 2*P_WIDTH + 1 + $clog2(P_N_IN);
    localparam int KW  = (P_N_IN  > 1) ? $clog2(P_N_IN)  : 1;
    localparam int NW  = (P_N_NEU > 1) ? $clog2(P_N_NEU) : 1;
    localparam int LW  = (P_N_LBL > 1) ? $clog2(P_N_LBL) : 1;
    localparam int NPC = P_N_NEU / P_N_LBL;
    localparam logic [TW-1:0]      TR_MAX = TW'(2**P_WIDTH);
    localparam logic [P_WIDTH-1:0] W_INIT = P_WIDTH'(2**(P_WIDTH-1));

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CMP, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [TW-1:0]       tr_q   [P_N_IN];
    logic [TW-1:0]       tr_d   [P_N_IN];
    logic [TW-1:0]       snap_q [P_N_IN];
    logic [P_WIDTH-1:0]  w_q    [P_N_NEU][P_N_IN];
    logic [AW-1:0]       thr_q  [P_N_NEU];
    logic [AW-1:0]       acc_q  [P_N_NEU];
    logic [LW-1:0]       lbl_q;
    logic                lbl_vld_q;
    logic                train_q;
    logic [NW-1:0]       win_q;
    logic                win_vld_q;
    logic                drop_q;

    logic [LW-1:0]       lbl_sel;
    logic [NW-1:0]       cmp_idx;
    logic                cmp_vld;
    logic [AW-1:0]       cmp_best;
    logic [TW-1:0]       k_snap;
    logic                win_in_cls;
    logic                las_hit;
    logic                gas_hit;

    function automatic logic [P_WIDTH-1:0] las_w(input logic [P_WIDTH-1:0] w,
                                                 input logic [TW-1:0] s);
        logic signed [TW:0] diff;
        logic signed [TW:0] nxt;
        diff = $signed({1'b0, s}) - $signed({2'b00, w});
        nxt  = $signed({2'b00, w}) + (diff >>> P_ETA);
        if (nxt < 0)
            return '0;
        if (nxt > $signed({2'b00, {P_WIDTH{1'b1}}}))
            return '1;
        return nxt[P_WIDTH-1:0];
    endfunction

    function automatic logic [AW-1:0] las_thr(input logic [AW-1:0] a,
                                              input logic [AW-1:0] t);
        logic signed [AW:0] diff;
        logic signed [AW:0] nxt;
        diff = $signed({1'b0, a}) - $signed({1'b0, t});
        nxt  = $signed({1'b0, t}) + (diff >>> P_ETA);
        return nxt[AW] ? '0 : nxt[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] gas_thr(input logic [AW-1:0] t);
        logic [AW-1:0] dec;
        dec = t >> P_ETA;
        if (dec == '0)
            dec = AW'(1);
        return (t > dec) ? t - dec : '0;
    endfunction

    // An event on a channel overrides a coincident decay tick.
    always_comb begin
        for (int i = 0; i < P_N_IN; i++) begin
            tr_d[i] = tr_q[i];
            if (i_event[i])
                tr_d[i] = TR_MAX;
            else if (i_tick && tr_q[i] != '0)
                tr_d[i] = tr_q[i] - TW'(1);
        end
    end

    for (genvar g = 0; g < P_N_IN; g++) begin : g_tr
        assign o_tr[g*TW +: TW] = tr_q[g];
    end

    always_comb begin
        lbl_sel = '0;
        for (int i = P_N_LBL-1; i >= 0; i--)
            if (i_label[i])
                lbl_sel = LW'(i);
    end

    // Strict '>' keeps the lowest index on equal scores.
    always_comb begin
        cmp_vld  = 1'b0;
        cmp_idx  = '0;
        cmp_best = '0;
        for (int j = 0; j < P_N_NEU; j++) begin
            if (acc_q[j] >= thr_q[j] && (!cmp_vld || acc_q[j] > cmp_best)) begin
                cmp_vld  = 1'b1;
                cmp_idx  = NW'(j);
                cmp_best = acc_q[j];
            end
        end
    end

    assign k_snap = snap_q[k_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        o_spike    = '0;
        las_hit    = 1'b0;
        gas_hit    = 1'b0;
        win_in_cls = (int'(win_q) / NPC) == int'(lbl_q);
        case (state_q)
            S_IDLE: begin
                if (|i_event) begin
                    state_d = S_ACCUM;
                    k_d     = '0;
                end
            end
            S_ACCUM: begin
                k_d = k_q + KW'(1);
                if (k_q == KW'(P_N_IN-1))
                    state_d = S_CMP;
            end
            S_CMP: state_d = S_OUT;
            S_OUT: begin
                state_d = S_IDLE;
                if (win_vld_q)
                    o_spike[win_q] = 1'b1;
                if (train_q && lbl_vld_q) begin
                    if (win_vld_q && win_in_cls)
                        las_hit = 1'b1;
`ifdef ODESA_GAS_EN
                    else
                        gas_hit = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_drop  = drop_q;
    assign o_las   = las_hit;
    assign o_gas   = gas_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < P_N_IN; i++) begin
                tr_q[i]   <= '0;
                snap_q[i] <= '0;
            end
            for (int j = 0; j < P_N_NEU; j++) begin
                acc_q[j] <= '0;
                thr_q[j] <= '0;
                for (int i = 0; i < P_N_IN; i++)
                    w_q[j][i] <= W_INIT;
            end
            lbl_q     <= '0;
            lbl_vld_q <= 1'b0;
            train_q   <= 1'b0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            for (int i = 0; i < P_N_IN; i++)
                tr_q[i] <= tr_d[i];
            drop_q <= (state_q != S_IDLE) && (|i_event);
            case (state_q)
                S_IDLE: begin
                    if (|i_event) begin
                        for (int i = 0; i < P_N_IN; i++)
                            snap_q[i] <= tr_d[i];
                        for (int j = 0; j < P_N_NEU; j++)
                            acc_q[j] <= '0;
                        lbl_q     <= lbl_sel;
                        lbl_vld_q <= |i_label;
                        train_q   <= i_train_en;
                    end
                end
                S_ACCUM: begin
                    for (int j = 0; j < P_N_NEU; j++)
                        acc_q[j] <= acc_q[j] + AW'(w_q[j][k_q]) * AW'(k_snap);
                end
                S_CMP: begin
                    win_q     <= cmp_idx;
                    win_vld_q <= cmp_vld;
                end
                S_OUT: begin
                    if (las_hit) begin
                        for (int i = 0; i < P_N_IN; i++)
                            w_q[win_q][i] <= las_w(w_q[win_q][i], snap_q[i]);
                        thr_q[win_q] <= las_thr(acc_q[win_q], thr_q[win_q]);
                    end
                    if (gas_hit) begin
                        for (int j = 0; j < P_N_NEU; j++)
                            if ((j / NPC) == int'(lbl_q))
                                thr_q[j] <= gas_thr(thr_q[j]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
